conv1_relu: RTL and testbench

- First convolution stage of the classifier: 3x3 convolution, stride 1, zero-padding 1, over a 28x28 8-bit greyscale sketch, producing 16 feature maps of 28x28 with ReLU applied.
- Output is written into the feature-map buffer that the 2x2 max-pool stage reads.
- Write order is filter-major, then row, then column. This matches the pool's consumption order.
- Image, weights and biases are read via synchronous memory ports, one MAC per cycle.

---
 rtl/cnn_pkg.sv | 29 ++
 rtl/conv_tap_gen.sv | 51 +++++
 rtl/conv1_relu.sv | 145 ++++++++++++++
 tb/tb_conv1_relu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and feature-map addressing for the CNN stages.
package cnn_pkg;

    localparam int IMG_DIM  = 28;
    localparam int N_FILT   = 16;
    localparam int KSIZE    = 3;
    localparam int N_TAPS   = KSIZE * KSIZE;
    localparam int PIX_W    = 8;
    localparam int WGT_W    = 8;
    localparam int ACC_W    = 32;
    localparam int FM_DEPTH = N_FILT * IMG_DIM * IMG_DIM;
    localparam int FM_AW    = $clog2(FM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_MAC,
        ST_WRITE,
        ST_DONE
    } conv_state_e;

    // Linear feature-map address: filter-major, then row, then column.
    function automatic logic [FM_AW-1:0] fm_index(input logic [3:0] f,
                                                  input logic [4:0] r,
                                                  input logic [4:0] c);
        return FM_AW'(int'(f) * IMG_DIM * IMG_DIM + int'(r) * IMG_DIM + int'(c));
    endfunction

endpackage

// File: rtl/conv_tap_gen.sv
// Maps an output pixel (r,c) and kernel tap t to the source image address and
// a pad flag for taps that fall outside the image (zero padding of one pixel).
module conv_tap_gen
    import cnn_pkg::*;
(
    input  logic [4:0] r,
    input  logic [4:0] c,
    input  logic [3:0] t,
    output logic [9:0] pix_addr,
    output logic [3:0] wgt_off,
    output logic       pad
);

    localparam logic signed [6:0] DIM_S = 7'(IMG_DIM);

    logic              tap_ok;
    logic [1:0]        kr;
    logic [1:0]        kc;
    logic signed [6:0] pr;
    logic signed [6:0] pc;

    // Split the tap index into kernel row/column; indices past the last tap are invalid.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        tap_ok = 1'b1;
        kr     = 2'd0;
        kc     = 2'd0;
        case (t)
            4'd0: begin kr = 2'd0; kc = 2'd0; end
            4'd1: begin kr = 2'd0; kc = 2'd1; end
            4'd2: begin kr = 2'd0; kc = 2'd2; end
            4'd3: begin kr = 2'd1; kc = 2'd0; end
            4'd4: begin kr = 2'd1; kc = 2'd1; end
            4'd5: begin kr = 2'd1; kc = 2'd2; end
            4'd6: begin kr = 2'd2; kc = 2'd0; end
            4'd7: begin kr = 2'd2; kc = 2'd1; end
            4'd8: begin kr = 2'd2; kc = 2'd2; end
            default: tap_ok = 1'b0;
        endcase
    end

    // Source coordinate is (r+kr-1, c+kc-1); anything outside the image is padding.
    always_comb begin
        pr       = $signed({2'b00, r}) + $signed({5'b00000, kr}) - 7'sd1;
        pc       = $signed({2'b00, c}) + $signed({5'b00000, kc}) - 7'sd1;
        pad      = !tap_ok || (pr < 0) || (pr >= DIM_S) || (pc < 0) || (pc >= DIM_S);
        pix_addr = pad ? '0 : 10'(pr) * 10'(IMG_DIM) + 10'(pc);
        wgt_off  = t;
    end

endmodule

// File: rtl/conv1_relu.sv
// First convolution layer: 3x3, stride 1, zero padding 1, ReLU, one MAC per cycle.
// Each output pixel takes an 11-cycle slot: BIAS, 9 x MAC, WRITE.
module conv1_relu
    import cnn_pkg::*;
#(
    parameter int NUM_FILT = N_FILT
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [9:0]       pix_addr,
    input  logic [PIX_W-1:0] pix_data,
    output logic [7:0]       wgt_addr,
    input  logic [WGT_W-1:0] wgt_data,
    output logic [3:0]       bias_addr,
    input  logic [ACC_W-1:0] bias_data,
    output logic             fm_we,
    output logic [FM_AW-1:0] fm_addr,
    output logic [ACC_W-1:0] fm_data
);

    localparam logic [4:0] LAST_RC = 5'(IMG_DIM - 1);
    localparam logic [3:0] LAST_F  = 4'(NUM_FILT - 1);
    localparam logic [3:0] LAST_T  = 4'(N_TAPS - 1);

    conv_state_e       state_q, state_d;
    logic [3:0]        f_q, f_d;
    logic [4:0]        r_q, r_d;
    logic [4:0]        c_q, c_d;
    logic [3:0]        t_q, t_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              pad_q, pad_d;

    logic [3:0]        tap_sel;
    logic              issue;
    logic [9:0]        tap_pix;
    logic [3:0]        tap_off;
    logic              tap_pad;
    logic              last_pix;
    logic signed [8:0] pix_s;
    logic signed [16:0] prod;
    logic [ACC_W-1:0]  prod_ext;

    // BIAS issues tap 0; MAC cycle t issues tap t+1 (tap 9 does not exist).
    assign tap_sel  = (state_q == ST_BIAS) ? 4'd0 : t_q + 4'd1;
    assign issue    = (state_q == ST_BIAS) || ((state_q == ST_MAC) && (t_q != LAST_T));
    assign last_pix = (f_q == LAST_F) && (r_q == LAST_RC) && (c_q == LAST_RC);

    conv_tap_gen u_tap_gen (
        .r        (r_q),
        .c        (c_q),
        .t        (tap_sel),
        .pix_addr (tap_pix),
        .wgt_off  (tap_off),
        .pad      (tap_pad)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples values from before the edge.
        if (!reset_n) begin
            state_q <= ST_IDLE;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            r_q     <= r_d;
            c_q     <= c_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            pad_q   <= pad_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_BIAS;
            ST_BIAS:  state_d = ST_MAC;
            ST_MAC:   if (t_q == LAST_T) state_d = ST_WRITE;
            ST_WRITE: state_d = last_pix ? ST_DONE : ST_BIAS;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Signed product of zero-extended pixel and weight; padded taps contribute zero.
    always_comb begin
        pix_s    = $signed({1'b0, pix_data});
        prod     = pix_s * $signed(wgt_data);
        prod_ext = pad_q ? '0 : {{(ACC_W - 17){prod[16]}}, prod};
    end

    // Tap counter, accumulator (wrapping) and pixel/row/filter counters.
    always_comb begin
        f_d   = f_q;
        r_d   = r_q;
        c_d   = c_q;
        t_d   = t_q;
        acc_d = acc_q;
        pad_d = tap_pad;
        case (state_q)
            ST_MAC: begin
                t_d   = (t_q == LAST_T) ? 4'd0 : t_q + 4'd1;
                acc_d = ((t_q == 4'd0) ? bias_data : acc_q) + prod_ext;
            end
            ST_WRITE: begin
                if (c_q != LAST_RC) begin
                    c_d = c_q + 5'd1;
                end else begin
                    c_d = '0;
                    if (r_q != LAST_RC) begin
                        r_d = r_q + 5'd1;
                    end else begin
                        r_d = '0;
                        f_d = last_pix ? 4'd0 : f_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; addresses and write data are zero when not in use.
    always_comb begin
        busy      = (state_q == ST_BIAS) || (state_q == ST_MAC) || (state_q == ST_WRITE);
        done      = (state_q == ST_DONE);
        fm_we     = (state_q == ST_WRITE);
        pix_addr  = issue ? tap_pix : '0;
        wgt_addr  = issue ? 8'(int'(f_q) * N_TAPS + int'(tap_off)) : '0;
        bias_addr = (state_q == ST_BIAS) ? f_q : '0;
        fm_addr   = fm_we ? fm_index(f_q, r_q, c_q) : '0;
        fm_data   = (fm_we && !acc_q[ACC_W-1]) ? acc_q : '0;
    end

endmodule

// File: tb/tb_conv1_relu.sv
// Scoreboard bench for conv1_relu: a loop-based convolution model fills the
// expected-write queue at launch; a negedge monitor pops and compares each write.
module tb_conv1_relu;

    localparam int NF      = 2;
    localparam int DIM     = 28;
    localparam int PLANE   = DIM * DIM;
    localparam int N_WR    = NF * PLANE;
    localparam int RUN_CYC = N_WR * 11;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [9:0]  pix_addr;
    logic [7:0]  pix_data;
    logic [7:0]  wgt_addr;
    logic [7:0]  wgt_data;
    logic [3:0]  bias_addr;
    logic [31:0] bias_data;
    logic        fm_we;
    logic [13:0] fm_addr;
    logic [31:0] fm_data;

    conv1_relu #(.NUM_FILT(NF)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .wgt_addr  (wgt_addr),
        .wgt_data  (wgt_data),
        .bias_addr (bias_addr),
        .bias_data (bias_data),
        .fm_we     (fm_we),
        .fm_addr   (fm_addr),
        .fm_data   (fm_data)
    );

    always #5 clk = ~clk;

    logic [7:0]  img  [PLANE];
    logic [7:0]  wgt  [256];
    logic [31:0] bias [16];
    logic [31:0] obs  [N_WR];
    exp_t        sb[$];
    exp_t        mon_e;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int first_we_cyc = -1;

    // Synchronous memories, one-cycle latency; out-of-image addresses return junk.
    always @(posedge clk) begin
        pix_data  <= (int'(pix_addr) < PLANE) ? img[pix_addr] : 8'hA5;
        wgt_data  <= wgt[wgt_addr];
        bias_data <= bias[bias_addr];
        cyc       <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (fm_we) begin
            if (wr_cnt == 0) first_we_cyc = cyc;
            wr_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("fm_addr", fm_addr, mon_e.addr);
                check("fm_data", fm_data, mon_e.data);
            end
            if (int'(fm_addr) < N_WR) obs[fm_addr] = fm_data;
        end
        if (done) done_cnt++;
    end

    // Reference model: direct 3x3 zero-padded convolution with 32-bit wrap and ReLU.
    task automatic build_expected();
        int acc;
        int pr;
        int pc;
        sb.delete();
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    acc = int'(bias[f]);
                    for (int kr = 0; kr < 3; kr++)
                        for (int kc = 0; kc < 3; kc++) begin
                            pr = r + kr - 1;
                            pc = c + kc - 1;
                            if (pr >= 0 && pr < DIM && pc >= 0 && pc < DIM)
                                acc += int'(img[pr * DIM + pc]) * int'($signed(wgt[f * 9 + kr * 3 + kc]));
                        end
                    sb.push_back('{14'(f * PLANE + r * DIM + c), (acc < 0) ? 32'd0 : 32'(acc)});
                end
    endtask

    task automatic cfg_random();
        for (int i = 0; i < PLANE; i++) img[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) wgt[i] = 8'($urandom);
        wgt[4] = 8'h80;
        wgt[9] = 8'h7F;
        for (int i = 0; i < 16; i++) bias[i] = 32'(int'($urandom_range(0, 400000)) - 200000);
    endtask

    task automatic cfg_fill(input logic [7:0] p, input logic [7:0] w, input logic [31:0] b);
        for (int i = 0; i < PLANE; i++) img[i] = p;
        for (int i = 0; i < 256; i++) wgt[i] = w;
        for (int i = 0; i < 16; i++) bias[i] = b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check($sformatf("%s_busy", tag), busy, 0);
        check($sformatf("%s_done", tag), done, 0);
        check($sformatf("%s_fm_we", tag), fm_we, 0);
        check($sformatf("%s_addrs", tag), {pix_addr, wgt_addr, bias_addr, fm_addr}, 0);
        check($sformatf("%s_fm_data", tag), fm_data, 0);
    endtask

    // Launch one layer and check ordering, latency, write count and a single done pulse.
    task automatic run_layer(input string tag, input bit poke_start);
        int  e0;
        int  done_before;
        bit  got_done;
        build_expected();
        wr_cnt = 0;
        first_we_cyc = -1;
        done_before = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
        check($sformatf("%s_busy_after_start", tag), busy, 1);
        got_done = 1'b0;
        for (int i = 1; i <= RUN_CYC + 50; i++) begin
            @(negedge clk);
            start = (poke_start && i % 700 == 0 && i < 3000) ? 1'b1 : 1'b0;
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check($sformatf("%s_done_seen", tag), got_done, 1);
        check($sformatf("%s_done_cycle", tag), cyc, e0 + RUN_CYC);
        check($sformatf("%s_first_write_cycle", tag), first_we_cyc, e0 + 10);
        check($sformatf("%s_write_count", tag), wr_cnt, N_WR);
        check($sformatf("%s_scoreboard_drained", tag), sb.size(), 0);
        repeat (3) @(negedge clk);
        check($sformatf("%s_done_once", tag), done_cnt - done_before, 1);
        check($sformatf("%s_idle_busy", tag), busy, 0);
    endtask

    initial begin
        bit saw_we;
        cfg_fill(8'd0, 8'd0, 32'd0);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;

        // Random image, weights and biases (signed weights, clipped and positive sums).
        cfg_random();
        run_layer("random", 1'b0);

        // Padding: all-ones image and weights give 4 at corners, 6 on edges, 9 inside.
        cfg_fill(8'd1, 8'd1, 32'd0);
        run_layer("ones", 1'b0);
        for (int f = 0; f < NF; f++) begin
            check($sformatf("ones_f%0d_corner_tl", f), obs[f * PLANE], 4);
            check($sformatf("ones_f%0d_corner_br", f), obs[f * PLANE + PLANE - 1], 4);
            check($sformatf("ones_f%0d_corner_bl", f), obs[f * PLANE + 27 * DIM], 4);
            check($sformatf("ones_f%0d_edge_top", f), obs[f * PLANE + 5], 6);
            check($sformatf("ones_f%0d_edge_left", f), obs[f * PLANE + 10 * DIM], 6);
            check($sformatf("ones_f%0d_interior", f), obs[f * PLANE + 10 * DIM + 10], 9);
        end

        // Abort mid-layer with a one-cycle reset.
        cfg_random();
        build_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_idle_outputs("abort");
        sb.delete();
        saw_we = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (fm_we || busy) saw_we = 1'b1;
        end
        check("abort_stays_idle", saw_we, 0);

        // Wrap: large bias plus positive products overflows negative, ReLU gives 0.
        // Start pulses during the run must be ignored.
        cfg_fill(8'd255, 8'd127, 32'h7FFF_FFF0);
        run_layer("wrap", 1'b1);
        check("wrap_interior_zero", obs[PLANE + 14 * DIM + 14], 0);
        check("wrap_corner_zero", obs[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
